// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter family.
//   arb_state_e : arbiter FSM state, 2-bit encoding
//                 (idle = 0, issue = 1, wait = 2, done = 3).
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle  = 2'd0,
    ArbIssue = 2'd1,
    ArbWait  = 2'd2,
    ArbDone  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Purely combinational round-robin chooser.
// The search starts at last_i + 1 and wraps modulo PORT_COUNT, so the previous
// winner has the lowest priority.
//   req_i   : per-port request vector
//   last_i  : index of the previous winner
//   grant_o : index of the chosen port (0 when nothing is requesting)
//   any_o   : high when at least one port is requesting
module rr_pick #(
  parameter int unsigned PORT_COUNT = 2,
  parameter int unsigned PORT_BITS  = 1
) (
  input  logic [PORT_COUNT-1:0] req_i,
  input  logic [PORT_BITS-1:0]  last_i,
  output logic [PORT_BITS-1:0]  grant_o,
  output logic                  any_o
);

  logic [PORT_BITS-1:0] idx;

  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    idx     = '0;
    // Offset PORT_COUNT lands back on last_i itself, so a lone requester that
    // won last time is still served.
    for (int unsigned off = 1; off <= PORT_COUNT; off++) begin
      idx = PORT_BITS'((32'(last_i) + off) % PORT_COUNT);
      if (!any_o && req_i[idx]) begin
        any_o   = 1'b1;
        grant_o = idx;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one downstream memory port between PORT_COUNT
// requesters. A winner's address, data and direction are latched in idle, a
// single-cycle mre/mwe strobe is issued, the downstream mready handshake is
// tracked, and read data is returned in a register with a one-cycle
// port_ready pulse to the winner.
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   port_addr_i/din_i   : packed per-port address / write data (port i at i*W)
//   port_re_i/we_i      : level requests, held until port_ready_o[i]
//   port_ready_o        : one-cycle completion pulse to the granted port
//   port_dout_o         : read data, broadcast, valid with port_ready_o
//   maddr_o, mout_o     : registered downstream address / write data
//   mre_o, mwe_o        : downstream read / write strobes
//   min_i, mready_i     : downstream read data / idle flag
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned WORD_WIDTH = 64,
  parameter int unsigned PORT_COUNT = 2,
  parameter int unsigned PORT_BITS  = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [PORT_COUNT*ADDR_WIDTH-1:0] port_addr_i,
  input  logic [PORT_COUNT*WORD_WIDTH-1:0] port_din_i,
  input  logic [PORT_COUNT-1:0]            port_re_i,
  input  logic [PORT_COUNT-1:0]            port_we_i,
  output logic [PORT_COUNT-1:0]            port_ready_o,
  output logic [WORD_WIDTH-1:0]            port_dout_o,
  output logic [ADDR_WIDTH-1:0]            maddr_o,
  output logic [WORD_WIDTH-1:0]            mout_o,
  output logic                             mre_o,
  output logic                             mwe_o,
  input  logic [WORD_WIDTH-1:0]            min_i,
  input  logic                             mready_i
);

  arb_state_e             state_q;
  logic [PORT_BITS-1:0]   grant_q;
  logic [PORT_BITS-1:0]   last_q;
  logic                   is_read_q;
  logic                   mre_q;
  logic                   mwe_q;
  logic [PORT_COUNT-1:0]  port_ready_q;
  logic [WORD_WIDTH-1:0]  port_dout_q;
  logic [ADDR_WIDTH-1:0]  maddr_q;
  logic [WORD_WIDTH-1:0]  mout_q;

  logic [PORT_COUNT-1:0]  req;
  logic [PORT_BITS-1:0]   pick_grant;
  logic                   pick_any;
  logic [ADDR_WIDTH-1:0]  addr_arr [PORT_COUNT];
  logic [WORD_WIDTH-1:0]  din_arr  [PORT_COUNT];

  // A port asserting both re and we is treated as a read; its we stays
  // pending and wins a later grant as a separate write.
  assign req = port_re_i | port_we_i;

  always_comb begin
    for (int i = 0; i < PORT_COUNT; i++) begin
      addr_arr[i] = port_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
      din_arr[i]  = port_din_i[i*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  rr_pick #(
    .PORT_COUNT (PORT_COUNT),
    .PORT_BITS  (PORT_BITS)
  ) u_rr_pick (
    .req_i   (req),
    .last_i  (last_q),
    .grant_o (pick_grant),
    .any_o   (pick_any)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ArbIdle;
      grant_q      <= '0;
      last_q       <= PORT_BITS'(PORT_COUNT - 1);  // port 0 wins first
      is_read_q    <= 1'b0;
      mre_q        <= 1'b0;
      mwe_q        <= 1'b0;
      port_ready_q <= '0;
      port_dout_q  <= '0;
      maddr_q      <= '0;
      mout_q       <= '0;
    end else begin
      unique case (state_q)
        ArbIdle: begin
          // Selection uses the current inputs, so a withdrawn request is
          // never granted.
          if (pick_any && mready_i) begin
            grant_q   <= pick_grant;
            maddr_q   <= addr_arr[pick_grant];
            mout_q    <= din_arr[pick_grant];
            is_read_q <= port_re_i[pick_grant];
            mre_q     <= port_re_i[pick_grant];
            mwe_q     <= !port_re_i[pick_grant];
            state_q   <= ArbIssue;
          end
        end
        ArbIssue: begin
          mre_q   <= 1'b0;
          mwe_q   <= 1'b0;
          state_q <= ArbWait;
        end
        ArbWait: begin
          if (mready_i) begin
            if (is_read_q) begin
              port_dout_q <= min_i;
            end
            port_ready_q <= PORT_COUNT'(1) << grant_q;
            state_q      <= ArbDone;
          end
        end
        ArbDone: begin
          port_ready_q <= '0;
          last_q       <= grant_q;
          state_q      <= ArbIdle;
        end
        default: state_q <= ArbIdle;
      endcase
    end
  end

  assign port_ready_o = port_ready_q;
  assign port_dout_o  = port_dout_q;
  assign maddr_o      = maddr_q;
  assign mout_o       = mout_q;
  assign mre_o        = mre_q;
  assign mwe_o        = mwe_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single transactions, plus hand sequences for
// contention, read+write on one port and reset in the middle of a wait.
// A scoreboard queue holds the expected {port_ready, port_dout} of every
// transaction pushed when it is driven and popped on each port_ready pulse.
module tb_mem_arbiter;

  localparam int unsigned AW = 64;
  localparam int unsigned WW = 64;
  localparam int unsigned PC = 2;
  localparam int unsigned PB = 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [PC*AW-1:0] port_addr;
  logic [PC*WW-1:0] port_din;
  logic [PC-1:0]    port_re;
  logic [PC-1:0]    port_we;
  logic [PC-1:0]    port_ready;
  logic [WW-1:0]    port_dout;
  logic [AW-1:0]    maddr;
  logic [WW-1:0]    mout;
  logic             mre;
  logic             mwe;
  logic [WW-1:0]    min;
  logic             mready;

  mem_arbiter #(
    .ADDR_WIDTH (AW),
    .WORD_WIDTH (WW),
    .PORT_COUNT (PC),
    .PORT_BITS  (PB)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .port_addr_i  (port_addr),
    .port_din_i   (port_din),
    .port_re_i    (port_re),
    .port_we_i    (port_we),
    .port_ready_o (port_ready),
    .port_dout_o  (port_dout),
    .maddr_o      (maddr),
    .mout_o       (mout),
    .mre_o        (mre),
    .mwe_o        (mwe),
    .min_i        (min),
    .mready_i     (mready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [63:0] rd_data(input logic [63:0] a);
    return (a == 64'h40) ? 64'hDEAD : (a ^ 64'h5A5A_0000_0000_F00D);
  endfunction

  // Downstream model: drops mready the cycle after a strobe, keeps it low for
  // busy_cfg cycles, then raises it again. hold_low forces it low externally.
  logic model_rdy = 1'b1;
  logic hold_low  = 1'b0;
  int   busy_cfg  = 1;
  int   busy_left = 0;
  assign mready = model_rdy & ~hold_low;

  always @(negedge clk) begin
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) model_rdy = 1'b1;
    end
    if (mre || mwe) begin
      model_rdy = 1'b0;
      busy_left = busy_cfg + 1;
      min       = rd_data(maddr);
    end
  end

  typedef struct packed {
    logic [1:0]  rdy;
    logic [63:0] dout;
  } sb_item_t;

  sb_item_t    sb[$];
  logic [63:0] model_dout = '0;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && port_ready !== '0) begin
      sb_item_t it;
      check("ready one-hot", 64'($countones(port_ready)), 64'd1);
      if (sb.size() == 0) begin
        check("unexpected ready", 64'(port_ready), 64'd0);
      end else begin
        it = sb.pop_front();
        check("sb port_ready", 64'(port_ready), 64'(it.rdy));
        check("sb port_dout", port_dout, it.dout);
      end
    end
  end

  typedef struct packed {
    logic [1:0]  re;
    logic [1:0]  we;
    logic [63:0] a0;
    logic [63:0] a1;
    logic [63:0] d0;
    logic [63:0] d1;
    int          busy;
    int          hold;
    logic [1:0]  rdy;
    logic        rd;
    logic [63:0] addr;
    logic [63:0] din;
  } vec_t;

  vec_t vecs[8];

  // One complete transaction: request at an idle-cycle negedge, check strobe
  // timing and contents, address stability, and port_ready latency.
  task automatic run_txn(input vec_t v, input int id);
    int    start;
    int    strobes;
    bit    done;
    bit    stable_ok;
    string nm;
    nm = $sformatf("v%0d", id);
    @(negedge clk);
    busy_cfg = v.busy;
    if (v.rd) model_dout = rd_data(v.addr);
    sb.push_back('{rdy: v.rdy, dout: model_dout});
    port_addr = {v.a1, v.a0};
    port_din  = {v.d1, v.d0};
    hold_low  = (v.hold > 0);
    port_re   = v.re;
    port_we   = v.we;
    start     = cyc;
    strobes   = 0;
    done      = 1'b0;
    stable_ok = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (v.hold > 0 && cyc == start + v.hold) hold_low = 1'b0;
      if (mre || mwe) begin
        strobes++;
        if (strobes == 1) begin
          check({nm, " strobe cycle"}, 64'(cyc), 64'(start + v.hold + 1));
          check({nm, " mre"}, 64'(mre), 64'(v.rd));
          check({nm, " mwe"}, 64'(mwe), 64'(!v.rd));
          check({nm, " maddr"}, maddr, v.addr);
          if (!v.rd) check({nm, " mout"}, mout, v.din);
        end
      end
      if (strobes > 0 && maddr !== v.addr) stable_ok = 1'b0;
      if (port_ready !== '0) begin
        done = 1'b1;
        check({nm, " ready cycle"}, 64'(cyc), 64'(start + v.hold + 3 + v.busy));
        port_re = '0;
        port_we = '0;
      end
    end
    hold_low = 1'b0;
    check({nm, " completed"}, 64'(done), 64'd1);
    check({nm, " single strobe"}, 64'(strobes), 64'd1);
    check({nm, " maddr stable"}, 64'(stable_ok), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles, required fewer", cyc);
    $fatal(1);
  end

  initial begin
    int got;
    int nstb;
    //           re     we     a0      a1      d0        d1        busy hold rdy    rd    addr    din
    vecs[0] = '{2'b01, 2'b00, 64'h40, 64'h0, 64'h0, 64'h0, 1, 0, 2'b01, 1'b1, 64'h40, 64'h0};
    vecs[1] = '{2'b00, 2'b10, 64'h0, 64'h8, 64'h0, 64'h1234, 1, 0, 2'b10, 1'b0, 64'h8,
                64'h1234};
    vecs[2] = '{2'b11, 2'b00, 64'h300, 64'h400, 64'h0, 64'h0, 0, 0, 2'b01, 1'b1, 64'h300,
                64'h0};
    vecs[3] = '{2'b11, 2'b00, 64'h500, 64'h600, 64'h0, 64'h0, 2, 0, 2'b10, 1'b1, 64'h600,
                64'h0};
    vecs[4] = '{2'b00, 2'b01, 64'h10, 64'h0, 64'hCAFE, 64'h0, 20, 0, 2'b01, 1'b0, 64'h10,
                64'hCAFE};
    vecs[5] = '{2'b10, 2'b00, 64'h0, 64'h18, 64'h0, 64'h0, 1, 5, 2'b10, 1'b1, 64'h18, 64'h0};
    vecs[6] = '{2'b10, 2'b10, 64'h0, 64'h20, 64'h0, 64'h77, 1, 0, 2'b10, 1'b1, 64'h20,
                64'h77};
    vecs[7] = '{2'b11, 2'b00, 64'h800, 64'h900, 64'h0, 64'h0, 1, 0, 2'b01, 1'b1, 64'h800,
                64'h0};

    port_addr = '0;
    port_din  = '0;
    port_re   = '0;
    port_we   = '0;
    min       = '0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset mre", 64'(mre), 64'd0);
    check("reset mwe", 64'(mwe), 64'd0);
    check("reset port_ready", 64'(port_ready), 64'd0);
    check("reset maddr", maddr, 64'd0);
    check("reset mout", mout, 64'd0);
    check("reset port_dout", port_dout, 64'd0);

    for (int i = 0; i < 7; i++) run_txn(vecs[i], i);

    // Contention: both ports read continuously; order must alternate 0,1,0,1.
    @(negedge clk);
    busy_cfg  = 1;
    port_addr = {64'h200, 64'h100};
    port_we   = '0;
    port_re   = 2'b11;
    for (int j = 0; j < 4; j++) begin
      model_dout = rd_data((j % 2 == 1) ? 64'h200 : 64'h100);
      sb.push_back('{rdy: (j % 2 == 1) ? 2'b10 : 2'b01, dout: model_dout});
    end
    got = 0;
    for (int k = 0; k < 200 && got < 4; k++) begin
      @(negedge clk);
      if (port_ready !== '0) begin
        got++;
        if (got == 4) port_re = '0;
      end
    end
    check("contention count", 64'(got), 64'd4);
    @(negedge clk);
    check("contention drained", 64'(sb.size()), 64'd0);

    // Port 0 asserts re and we together: a read first, then the pending write.
    port_addr = {64'h0, 64'h28};
    port_din  = {64'h0, 64'hBEEF};
    model_dout = rd_data(64'h28);
    sb.push_back('{rdy: 2'b01, dout: model_dout});
    sb.push_back('{rdy: 2'b01, dout: model_dout});
    port_re = 2'b01;
    port_we = 2'b01;
    got  = 0;
    nstb = 0;
    for (int k = 0; k < 200 && got < 2; k++) begin
      @(negedge clk);
      if (mre || mwe) begin
        nstb++;
        if (nstb == 1) check("rw first strobe is read", 64'(mre), 64'd1);
        else begin
          check("rw second strobe is write", 64'(mwe), 64'd1);
          check("rw write data", mout, 64'hBEEF);
        end
      end
      if (port_ready !== '0) begin
        got++;
        port_re = '0;
        if (got == 2) port_we = '0;
      end
    end
    check("rw completions", 64'(got), 64'd2);
    check("rw strobes", 64'(nstb), 64'd2);

    // Reset while waiting on a slow downstream.
    @(negedge clk);
    busy_cfg  = 20;
    port_addr = {64'h0, 64'h700};
    port_re   = 2'b01;
    @(negedge clk);
    @(negedge clk);
    check("pre-reset maddr", maddr, 64'h700);
    #2 rst_n = 1'b0;
    #1;
    check("mid reset mre", 64'(mre), 64'd0);
    check("mid reset mwe", 64'(mwe), 64'd0);
    check("mid reset port_ready", 64'(port_ready), 64'd0);
    check("mid reset maddr", maddr, 64'd0);
    check("mid reset mout", mout, 64'd0);
    check("mid reset port_dout", port_dout, 64'd0);
    port_re    = '0;
    model_dout = '0;
    for (int k = 0; k < 100 && !mready; k++) @(negedge clk);
    check("downstream idle before release", 64'(mready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(vecs[7], 7);

    @(negedge clk);
    check("scoreboard empty at end", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares one memory-side port (a `cache` upstream interface or main memory) between `PORT_COUNT` requesters. Each requester holds a level request until it receives a one-cycle `port_ready` pulse. The arbiter latches the winner's address, data and direction, then issues a single-cycle `mre`/`mwe` strobe. It tracks the downstream `mready` busy/idle handshake and returns read data in a register. It sits between processor/trace ports and the top of the memory hierarchy.

## Interface
- `ADDR_WIDTH`, 64: address bits.
- `WORD_WIDTH`, 64: data bits.
- `PORT_COUNT`, 2: requesters (≥1).
- `PORT_BITS`, 1: index width, ≥ clog2(PORT_COUNT), min 1.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `port_addr`  in  PORT_COUNT*ADDR_WIDTH  per-port address; port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- `port_din`  in  PORT_COUNT*WORD_WIDTH  per-port write data.
- `port_re`  in  PORT_COUNT  read request; level, held until `port_ready[i]`.
- `port_we`  in  PORT_COUNT  write request; level, held until `port_ready[i]`.
- `port_ready`  out  PORT_COUNT  one-cycle completion pulse to the granted port.
- `port_dout`  out  WORD_WIDTH  read data, broadcast; valid while `port_ready` is high.
- `maddr`  out  ADDR_WIDTH  downstream address, registered.
- `mout`  out  WORD_WIDTH  downstream write data, registered.
- `mre`  out  1  downstream read strobe.
- `mwe`  out  1  downstream write strobe.
- `min`  in  WORD_WIDTH  downstream read data.
- `mready`  in  1  downstream idle/ready.

## Operation
- States: IDLE, ISSUE, WAIT, DONE; 2-bit encoding.
- **IDLE**
  - A port is requesting if `port_re[i]|port_we[i]`.
  - When any port requests and `mready`=1:
    - pick the winner by round-robin, searching from `last+1` modulo PORT_COUNT with wrap;
    - latch `grant`, `maddr`, `mout` and `is_read` (= `port_re[grant]`);
    - go to ISSUE.
  - When `mready`=0, stay in IDLE and latch nothing.
- **Read/write priority:** if a port asserts both `re` and `we`, it is a read. The `we` remains pending and is served as a separate transaction on a later grant.
- **ISSUE**
  - Exactly one cycle.
  - `mre`=`is_read` and `mwe`=!`is_read`, both from registers.
  - Go to WAIT.
- **WAIT**
  - `mre`=`mwe`=0.
  - `mready` is sampled starting from WAIT's first cycle; the downstream drops `mready` the cycle after the strobe.
  - On `mready`=1: capture `min` into `port_dout` if `is_read` (a write leaves `port_dout` unchanged), then go to DONE.
- **DONE**
  - `port_ready[grant]`=1 for one cycle; all other bits are 0.
  - `last` <= `grant`.
  - Go to IDLE.
- `maddr`/`mout` hold from latch through DONE; they change only on an IDLE grant.
- **Requester obligation:** drop `re`/`we` on the edge ending the `port_ready` cycle. A request still high in the following IDLE is a new transaction.
- A port that deasserts its request before grant is never served. No stale grant is issued, because selection uses current inputs.
- Single-port configuration (PORT_COUNT=1): the round-robin reduces to always granting port 0.

## Timing
- **Reset values:**
  - state=IDLE, `last`=PORT_COUNT-1 (port 0 wins first);
  - `mre`=`mwe`=0, `port_ready`=0, `maddr`=0, `mout`=0, `port_dout`=0.
- **Reset mid-transaction:** immediate return to IDLE, strobes cleared. No abort is signalled downstream; the bench must wait for `mready` before issuing new traffic.
- **Latency:** request at cycle 0 with `mready`=1 → ISSUE cycle 1 → WAIT from cycle 2.
  - Downstream returning `mready` at cycle 3 gives `port_ready` at cycle 4.
  - In general, `port_ready` comes one cycle after the first `mready`=1 seen in WAIT.
- **Throughput:** at most one transaction per 4 cycles.
- **Simultaneous events:** a request arriving during ISSUE/WAIT/DONE waits for IDLE. Arbitration considers only requests present in the IDLE cycle.

## Structure
- Shared include `memsim_defs.vh`: state encodings (ARB_IDLE=0, ARB_ISSUE=1, ARB_WAIT=2, ARB_DONE=3).
- Sub-module `rr_pick`: purely combinational round-robin chooser.
  - Parameter: PORT_COUNT.
  - Inputs: `req` vector, `last` index.
  - Outputs: `grant` index, `any` flag.
  - Reused by later multi-port memory blocks.

## Test plan
- **Single read:** port 0 `re`, addr 0x40. Downstream model returns `min`=0xDEAD with `mready` low for 1 cycle. Expect:
  - `mre` high only at cycle 1, `maddr`=0x40;
  - `port_ready`=2'b01 and `port_dout`=0xDEAD at cycle 4.
- **Contention:** both ports request reads continuously, 4 transactions total. Expect grant order 0,1,0,1 and `port_ready` never to both ports in the same cycle.
- **Write:** port 1 `we`, addr 0x8, din 0x1234. Expect:
  - `mwe` one cycle with `mout`=0x1234;
  - `port_dout` unchanged, `port_ready`=2'b10.
- **Backpressure:** `mready`=0 at request time for 5 cycles. Expect the arbiter to stay in IDLE with no strobe, and to issue the cycle after `mready` rises.
- **Slow downstream:** `mready` held low 20 cycles in WAIT. Expect `maddr` stable throughout, no second strobe, and `port_ready` exactly one cycle after `mready` returns.
- **Reset mid-WAIT:** assert `rst`=0 asynchronously. Expect:
  - all outputs at reset values within the same cycle;
  - after release, port 0 is granted first.
